// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debug run controller for a single CPU.
//   Accepts debug commands (RUN, STEP, HALT, CPURST, breakpoint setup) over a
//   valid/ready handshake and drives the CPU clock enable and CPU reset.
//
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted when cmd_valid && cmd_ready at a clk edge
//   cmd_op     in   0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 CPURST, 5 SETBP0, 6 SETBP1, 7 CLRBP
//   cmd_arg    in   STEP count in [15:0], breakpoint address for SETBP0/1
//   pc         in   IF-stage PC of the controlled CPU
//   cpu_ce     out  CPU clock enable (combinational)
//   cpu_rstn   out  registered active-low CPU reset
//   halted     out  high while IDLE
//   done       out  one-cycle pulse when RUN/STEP ends
//   bp_hit     out  one-cycle pulse when RUN ends on a breakpoint
//   err        out  one-cycle pulse on an illegal accepted command
//   state      out  0 IDLE, 1 RUN, 2 STEP, 3 RESET
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic [31:0] pc,
    output logic        cpu_ce,
    output logic        cpu_rstn,
    output logic        halted,
    output logic        done,
    output logic        bp_hit,
    output logic        err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_RESET = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_RUN    = 3'd1,
        OP_STEP   = 3'd2,
        OP_HALT   = 3'd3,
        OP_CPURST = 3'd4,
        OP_SETBP0 = 3'd5,
        OP_SETBP1 = 3'd6,
        OP_CLRBP  = 3'd7
    } op_e;

    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

    state_e      state_q;
    logic [7:0]  rst_cnt_q;
    logic [15:0] step_cnt_q;
    logic [31:0] bp0_q, bp1_q;
    logic        bp0_en_q, bp1_en_q;
    logic        first_run_q;
    logic        cpu_rstn_q;
    logic        done_q, bp_hit_q, err_q;

    op_e  op;
    logic accept;
    logic hit;
    logic busy_illegal;

    assign op           = op_e'(cmd_op);
    assign cmd_ready    = (state_q != ST_RESET);
    assign accept       = cmd_valid && cmd_ready;
    assign busy_illegal = (op == OP_RUN) || (op == OP_STEP) || (op == OP_CPURST);

    // The first RUN cycle ignores breakpoints so a resume from a hit
    // executes the instruction at the breakpoint address.
    assign hit = ((bp0_en_q && (pc == bp0_q)) || (bp1_en_q && (pc == bp1_q)))
                 && !first_run_q;

    assign cpu_ce   = (state_q == ST_STEP) || ((state_q == ST_RUN) && !hit);
    assign cpu_rstn = cpu_rstn_q;
    assign halted   = (state_q == ST_IDLE);
    assign done     = done_q;
    assign bp_hit   = bp_hit_q;
    assign err      = err_q;
    assign state    = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= RST_LOAD;
            step_cnt_q  <= '0;
            bp0_q       <= '0;
            bp1_q       <= '0;
            bp0_en_q    <= 1'b0;
            bp1_en_q    <= 1'b0;
            first_run_q <= 1'b0;
            cpu_rstn_q  <= 1'b0;
            done_q      <= 1'b0;
            bp_hit_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            bp_hit_q <= 1'b0;
            err_q    <= 1'b0;

            // Breakpoint commands are state-independent (RESET never accepts).
            if (accept) begin
                case (op)
                    OP_SETBP0: begin bp0_q <= cmd_arg; bp0_en_q <= 1'b1; end
                    OP_SETBP1: begin bp1_q <= cmd_arg; bp1_en_q <= 1'b1; end
                    OP_CLRBP:  begin bp0_en_q <= 1'b0; bp1_en_q <= 1'b0; end
                    default: ;
                endcase
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_RUN: begin
                                state_q     <= ST_RUN;
                                first_run_q <= 1'b1;
                            end
                            OP_STEP: begin
                                state_q    <= ST_STEP;
                                step_cnt_q <= (cmd_arg[15:0] == 16'd0) ? 16'd1 : cmd_arg[15:0];
                            end
                            OP_CPURST: begin
                                state_q    <= ST_RESET;
                                rst_cnt_q  <= RST_LOAD;
                                cpu_rstn_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_RUN: begin
                    first_run_q <= 1'b0;
                    // A hit and a HALT in the same cycle end RUN once.
                    if (hit) begin
                        state_q  <= ST_IDLE;
                        done_q   <= 1'b1;
                        bp_hit_q <= 1'b1;
                    end else if (accept && (op == OP_HALT)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                    if (accept && busy_illegal) begin
                        err_q <= 1'b1;
                    end
                end

                ST_STEP: begin
                    step_cnt_q <= step_cnt_q - 16'd1;
                    if ((step_cnt_q == 16'd1) || (accept && (op == OP_HALT))) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                    if (accept && busy_illegal) begin
                        err_q <= 1'b1;
                    end
                end

                ST_RESET: begin
                    if (rst_cnt_q <= 8'd1) begin
                        state_q    <= ST_IDLE;
                        cpu_rstn_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        cpu_ce;
    logic        cpu_rstn;
    logic        halted;
    logic        done;
    logic        bp_hit;
    logic        err;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, STEP = 3'd2, HALT = 3'd3,
                           CPURST = 3'd4, SETBP0 = 3'd5, SETBP1 = 3'd6, CLRBP = 3'd7;

    cpu_run_ctrl #(.RST_CYCLES(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .pc        (pc),
        .cpu_ce    (cpu_ce),
        .cpu_rstn  (cpu_rstn),
        .halted    (halted),
        .done      (done),
        .bp_hit    (bp_hit),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_arg   = 32'd0;
    endtask

    // Counts cycles with cpu_rstn low until IDLE is reached (bounded).
    task automatic count_reset(output int low);
        int n;
        low = 0;
        n = 0;
        while (state !== 2'd0 && n < 50) begin
            if (cpu_rstn === 1'b0) low++;
            tick();
            n++;
        end
    endtask

    initial begin
        int ce_cnt, done_cnt, err_cnt, bph_cnt, low;
        logic ce, hit_ce;

        // ---- power-on reset ----
        tick(); tick();
        check("rst_state", 32'(state), 32'd3);
        check("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pulses", {29'd0, done, bp_hit, err}, 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);

        rstn = 1'b1;
        count_reset(low);
        check("por_low_cycles", 32'(low), 32'd4);
        check("por_state", 32'(state), 32'd0);
        check("por_halted", 32'(halted), 32'd1);
        check("por_ready", 32'(cmd_ready), 32'd1);
        check("por_cpu_rstn", 32'(cpu_rstn), 32'd1);

        // ---- STEP 3 ----
        issue(STEP, 32'd3);
        check("step3_state", 32'(state), 32'd2);
        ce_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            ce_cnt += int'(cpu_ce);
            tick();
            done_cnt += int'(done);
        end
        check("step3_ce", 32'(ce_cnt), 32'd3);
        check("step3_done", 32'(done_cnt), 32'd1);
        check("step3_state_end", 32'(state), 32'd0);

        // ---- STEP 0 treated as 1 ----
        issue(STEP, 32'd0);
        ce_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            ce_cnt += int'(cpu_ce);
            tick();
            done_cnt += int'(done);
        end
        check("step0_ce", 32'(ce_cnt), 32'd1);
        check("step0_done", 32'(done_cnt), 32'd1);

        // ---- breakpoint at 0x10, pc ramps by 4 per CPU cycle ----
        issue(SETBP0, 32'h10);
        check("setbp_state", 32'(state), 32'd0);
        pc = 32'h0;
        issue(RUN, 32'd0);
        ce_cnt = 0; done_cnt = 0; bph_cnt = 0; hit_ce = 1'bx;
        for (int i = 0; i < 20; i++) begin
            #1;
            ce = cpu_ce;
            ce_cnt += int'(ce);
            if (pc == 32'h10) hit_ce = ce;
            tick();
            done_cnt += int'(done);
            bph_cnt  += int'(bp_hit);
            if (ce) pc = pc + 32'd4;
            if (state == 2'd0) break;
        end
        check("bp_ce_cycles", 32'(ce_cnt), 32'd4);
        check("bp_ce_at_hit", 32'(hit_ce), 32'd0);
        check("bp_hit_pulse", 32'(bph_cnt), 32'd1);
        check("bp_done_pulse", 32'(done_cnt), 32'd1);
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_pc", pc, 32'h10);
        tick();
        check("bp_hit_one_cycle", 32'(bp_hit), 32'd0);

        // ---- resume past the breakpoint ----
        issue(RUN, 32'd0);
        ce_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            ce = cpu_ce;
            ce_cnt += int'(ce);
            tick();
            if (ce) pc = pc + 32'd4;
        end
        check("resume_ce", 32'(ce_cnt), 32'd3);
        check("resume_pc", pc, 32'h1C);
        issue(HALT, 32'd0);
        check("resume_halt_done", 32'(done), 32'd1);
        check("resume_halt_state", 32'(state), 32'd0);

        // ---- RUN then HALT after 5 cycles ----
        pc = 32'h100;
        issue(RUN, 32'd0);
        ce_cnt = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ce_cnt += int'(cpu_ce);
            tick();
        end
        ce_cnt += int'(cpu_ce);
        issue(HALT, 32'd0);
        done_cnt += int'(done);
        err_cnt  += int'(err);
        for (int i = 0; i < 5; i++) begin
            ce_cnt += int'(cpu_ce);
            tick();
            done_cnt += int'(done);
            err_cnt  += int'(err);
        end
        check("halt5_ce", 32'(ce_cnt), 32'd5);
        check("halt5_done", 32'(done_cnt), 32'd1);
        check("halt5_err", 32'(err_cnt), 32'd0);
        check("halt5_state", 32'(state), 32'd0);

        // ---- STEP during RUN is dropped with err ----
        issue(RUN, 32'd0);
        tick(); tick();
        issue(STEP, 32'd5);
        check("busy_err", 32'(err), 32'd1);
        check("busy_state", 32'(state), 32'd1);
        check("busy_ce", 32'(cpu_ce), 32'd1);
        tick();
        check("busy_err_one_cycle", 32'(err), 32'd0);
        check("busy_still_run", 32'(state), 32'd1);
        issue(HALT, 32'd0);
        check("busy_halt_state", 32'(state), 32'd0);

        // ---- CPURST in IDLE keeps breakpoints ----
        issue(CPURST, 32'd0);
        check("cpurst_state", 32'(state), 32'd3);
        check("cpurst_ready", 32'(cmd_ready), 32'd0);
        count_reset(low);
        check("cpurst_low_cycles", 32'(low), 32'd4);
        check("cpurst_cpu_rstn", 32'(cpu_rstn), 32'd1);

        // Breakpoint still armed: stalled pc at 0x10 hits on the second cycle;
        // HALT in that same hit cycle must give a single done.
        pc = 32'h10;
        issue(RUN, 32'd0);
        check("keepbp_first_ce", 32'(cpu_ce), 32'd1);
        tick();
        check("keepbp_hit_ce", 32'(cpu_ce), 32'd0);
        issue(HALT, 32'd0);
        done_cnt = int'(done); bph_cnt = int'(bp_hit);
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(done);
            bph_cnt  += int'(bp_hit);
        end
        check("hit_halt_done", 32'(done_cnt), 32'd1);
        check("hit_halt_bphit", 32'(bph_cnt), 32'd1);

        // ---- HALT on last STEP cycle gives a single done ----
        issue(STEP, 32'd2);
        tick();
        issue(HALT, 32'd0);
        done_cnt = int'(done);
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(done);
        end
        check("laststep_halt_done", 32'(done_cnt), 32'd1);
        check("laststep_state", 32'(state), 32'd0);

        // ---- async reset mid-STEP ----
        issue(STEP, 32'd10);
        tick(); tick();
        check("midstep_ce_before", 32'(cpu_ce), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_ce", 32'(cpu_ce), 32'd0);
        check("arst_state", 32'(state), 32'd3);
        check("arst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_pulses", {29'd0, done, bp_hit, err}, 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd0);
        tick();
        rstn = 1'b1;
        count_reset(low);
        check("arst_low_cycles", 32'(low), 32'd4);

        // Breakpoints cleared by rstn: pc stays at 0x10, no hit.
        pc = 32'h10;
        issue(RUN, 32'd0);
        ce_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            ce_cnt += int'(cpu_ce);
            tick();
        end
        check("arst_bp_cleared", 32'(ce_cnt), 32'd3);
        issue(HALT, 32'd0);
        check("final_state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 4, the number of cycles cpu_rstn is held low per CPU reset (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: debug command present.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: command accepted on a clk edge where cmd_valid=1 and cmd_ready=1.
REQ-006 The block SHALL have port cmd_op, input, 3 bits: 0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 CPURST, 5 SETBP0, 6 SETBP1, 7 CLRBP.
REQ-007 The block SHALL have port cmd_arg, input, 32 bits: STEP count in [15:0]; breakpoint address for SETBP0/1.
REQ-008 The block SHALL have port pc, input, 32 bits: IF-stage PC of the controlled CPU.
REQ-009 The block SHALL have port cpu_ce, output, 1 bit: CPU clock enable, one CPU cycle per clk cycle with cpu_ce=1.
REQ-010 The block SHALL have port cpu_rstn, output, 1 bit: registered active-low CPU reset.
REQ-011 The block SHALL have port halted, output, 1 bit: high in IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when RUN/STEP ends.
REQ-013 The block SHALL have port bp_hit, output, 1 bit: one-cycle pulse when RUN ends on a breakpoint.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal accepted command.
REQ-015 The block SHALL have port state, output, 2 bits: 0 IDLE, 1 RUN, 2 STEP, 3 RESET.

Function
REQ-016 cmd_ready SHALL be 1 in IDLE, RUN and STEP, and 0 in RESET.
REQ-017 Accepted commands SHALL take effect at the accepting edge: the new state is visible in the next cycle, and the first cpu_ce=1 occurs in that next cycle.
REQ-018 In IDLE: RUN SHALL go to RUN; STEP SHALL load step_cnt=cmd_arg[15:0] (0 treated as 1) and go to STEP; CPURST SHALL go to RESET; HALT and NOP SHALL be no-ops.
REQ-019 SETBP0/SETBP1 SHALL load bp0/bp1 address and set the matching enable; CLRBP SHALL clear both enables; these SHALL be legal in any state except RESET, with no state change.
REQ-020 In RUN or STEP, HALT SHALL go to IDLE and pulse done in the next cycle; RUN, STEP or CPURST there SHALL be dropped and pulse err in the next cycle.
REQ-021 cpu_ce SHALL be combinational: 1 in STEP; in RUN, 1 unless hit; 0 in IDLE and RESET.
REQ-022 hit SHALL be (bp0_en && pc==bp0) || (bp1_en && pc==bp1), qualified by first_run==0; first_run is set on entering RUN and cleared after the first RUN cycle, so resuming from a breakpoint executes it.
REQ-023 On hit in RUN, the block SHALL go to IDLE, with done and bp_hit pulsing in the following cycle; a CPU cycle SHALL NOT be issued in the hit cycle.
REQ-024 STEP SHALL assert cpu_ce for exactly step_cnt consecutive cycles, decrementing each cycle, then go to IDLE with done pulsing once; breakpoints SHALL be ignored in STEP.
REQ-025 A HALT accepted in the same cycle as a RUN hit or the last STEP cycle SHALL produce a single done pulse (no double pulse).
REQ-026 RESET SHALL hold cpu_rstn=0 for exactly RST_CYCLES cycles using an 8-bit counter, then go to IDLE with cpu_rstn=1 registered from the next cycle; breakpoint registers SHALL be preserved across CPURST.
REQ-027 The pulse outputs done, bp_hit and err SHALL be registered and never high for more than one cycle per event.

Reset
REQ-028 On rstn=0, asynchronously: state=RESET, rst_cnt=RST_CYCLES, cpu_rstn=0, cpu_ce=0, halted=0, done=bp_hit=err=0, bp0=bp1=0, enables=0, step_cnt=0.
REQ-029 After rstn deasserts, the block SHALL complete the RESET sequence per REQ-026 and reach IDLE with halted=1.
REQ-030 Assertion of rstn mid-RUN or mid-STEP SHALL abort immediately, with cpu_ce=0 in the same cycle.

Verification
REQ-031 Scenario: release rstn with RST_CYCLES=4 -> cpu_rstn low 4 cycles, then state=0, halted=1, cmd_ready=1.
REQ-032 Scenario: STEP arg=3 -> cpu_ce high exactly 3 cycles, done pulses once, state returns to 0; STEP arg=0 -> exactly 1 cycle.
REQ-033 Scenario: SETBP0 0x0000_0010, RUN, pc ramps 0x0,0x4,... -> cpu_ce drops in the cycle pc==0x10, bp_hit and done pulse, halted=1; a second RUN resumes past 0x10.
REQ-034 Scenario: RUN then HALT after 5 cycles -> cpu_ce high exactly 5 cycles, done pulses once, err=0.
REQ-035 Scenario: STEP issued during RUN -> err pulses, RUN continues uninterrupted; CPURST in IDLE -> cpu_rstn low 4 cycles, breakpoints still set.
REQ-036 Scenario: rstn asserted mid-STEP with step_cnt=10 -> cpu_ce=0 immediately, all outputs at their reset values.
